router_fsm: RTL

//   Packet-level control FSM of the 1x3 router. Sits directly upstream of router_reg
//   and drives its strobes: detect_add, lfd_state, ld_state, laf_state, full_state
//   and rst_int_reg. It also drives the FIFO write enable, the source busy flag and
//   the latched destination port.

---
 rtl/router_fsm.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/router_fsm.sv
// router_fsm: packet-level control FSM of the 1x3 router.
//   Decodes the header address, waits for an empty destination FIFO, then
//   sequences first-data, payload, full-stall and parity loading for router_reg.
//   Outputs are Moore, decoded from the registered state with no added latency;
//   the source is held off through busy whenever the FSM cannot accept data.
// Ports:
//   clk, reset            system clock; asynchronous active-high reset
//   packet_valid, data_in source handshake and header address bits
//   fifo_full, fifo_empty selected-FIFO full flag; per-port empty flags
//   soft_reset            per-port timeout reset (only the latched port counts)
//   parity_done, low_packet_valid  status from router_reg
//   addr_q                latched destination port
//   write_enb_reg         FIFO write strobe
//   detect_add .. rst_int_reg  one-hot state strobes to router_reg
//   busy                  source must hold data_in
module router_fsm #(
  parameter int NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 packet_valid,
  input  logic [1:0]           data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic [1:0]           addr_q,
  output logic                 write_enb_reg,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  localparam logic [1:0] LAST_ADDR = 2'(NUM_PORTS - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_addr;
  logic       w_addr_load;
  logic       w_addr_ok;
  logic [3:0] w_empty_pad;
  logic [3:0] w_soft_pad;

  // Pad the per-port flags to the full 2-bit address space so address 3
  // indexes a defined zero instead of falling off the vector.
  assign w_empty_pad = {{(4 - NUM_PORTS){1'b0}}, fifo_empty};
  assign w_soft_pad  = {{(4 - NUM_PORTS){1'b0}}, soft_reset};
  assign w_addr_ok   = (data_in <= LAST_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (w_addr_load) begin
        r_addr <= data_in;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_addr_load  = 1'b0;
    case (r_state)
      DECODE_ADDRESS: begin
        // Packets addressed to a non-existent port are silently dropped.
        if (packet_valid && w_addr_ok) begin
          w_addr_load  = 1'b1;
          w_next_state = w_empty_pad[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          w_next_state = FIFO_FULL_STATE;
        end else if (!packet_valid) begin
          w_next_state = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          w_next_state = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          w_next_state = DECODE_ADDRESS;
        end else if (low_packet_valid) begin
          w_next_state = LOAD_PARITY;
        end else begin
          w_next_state = LOAD_DATA;
        end
      end
      LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty_pad[r_addr]) begin
          w_next_state = LOAD_FIRST_DATA;
        end
      end
      default: w_next_state = DECODE_ADDRESS;
    endcase
    // A timeout on the port we are serving abandons the packet; timeouts on
    // other ports belong to their own traffic and are ignored here.
    if ((r_state != DECODE_ADDRESS) && w_soft_pad[r_addr]) begin
      w_next_state = DECODE_ADDRESS;
      w_addr_load  = 1'b0;
    end
  end

  always_comb begin
    write_enb_reg = 1'b0;
    busy          = 1'b0;
    case (r_state)
      LOAD_FIRST_DATA:    begin write_enb_reg = 1'b1; busy = 1'b1; end
      LOAD_DATA:          begin write_enb_reg = 1'b1; end
      FIFO_FULL_STATE:    begin busy = 1'b1; end
      LOAD_AFTER_FULL:    begin write_enb_reg = 1'b1; busy = 1'b1; end
      LOAD_PARITY:        begin write_enb_reg = 1'b1; busy = 1'b1; end
      CHECK_PARITY_ERROR: begin busy = 1'b1; end
      WAIT_TILL_EMPTY:    begin busy = 1'b1; end
      default:            begin write_enb_reg = 1'b0; busy = 1'b0; end
    endcase
  end

  assign addr_q      = r_addr;
  assign detect_add  = (r_state == DECODE_ADDRESS);
  assign lfd_state   = (r_state == LOAD_FIRST_DATA);
  assign ld_state    = (r_state == LOAD_DATA);
  assign full_state  = (r_state == FIFO_FULL_STATE);
  assign laf_state   = (r_state == LOAD_AFTER_FULL);
  assign rst_int_reg = (r_state == CHECK_PARITY_ERROR);

endmodule
